// File: rtl/alu_pipe.sv
// Handshaked ALU with a WIDTH-cycle shift-add multiplier and {N,V,C,Z} flags.
// Define ALU_PIPE_SAT_EN to saturate ADD/SUB (signed) and MUL (unsigned) results.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic [3:0]       OPCODE,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RES,
    output logic [3:0]       FLAGS,
    output logic             ERR,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               accept;

    logic [SHW-1:0]        sh;
    logic [WIDTH:0]        sum_w;
    logic [WIDTH:0]        diff_w;
    logic [WIDTH:0]        shl_w;
    logic [WIDTH:0]        shr_w;
    logic signed [WIDTH:0] sra_w;
    logic [WIDTH-1:0]      alu_res;
    logic [3:0]            alu_flags;
    logic                  alu_err;
    logic                  alu_c;
    logic                  alu_v;
    logic [WIDTH-1:0]      mul_res;
    logic [3:0]            mul_flags;
    logic                  mul_c;

    // A transfer happens on any edge where valid and ready are both high;
    // a HOLD result may be retired and a new op accepted on the same edge.
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        sh      = OP2[SHW-1:0];
        sum_w   = {1'b0, OP1} + {1'b0, OP2};
        diff_w  = {1'b0, OP1} - {1'b0, OP2};
        // Shifts are done one bit wider so the last bit shifted out lands in the guard bit.
        shl_w   = {1'b0, OP1} << sh;
        shr_w   = {OP1, 1'b0} >> sh;
        sra_w   = $signed({OP1, 1'b0}) >>> sh;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (OPCODE)
            4'd0: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum_w[WIDTH-1] != OP1[WIDTH-1]);
            end
            4'd1: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = ~diff_w[WIDTH];
                alu_v   = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff_w[WIDTH-1] != OP1[WIDTH-1]);
            end
            4'd2: alu_res = OP1 & OP2;
            4'd3: alu_res = OP1 | OP2;
            4'd4: alu_res = OP1 ^ OP2;
            4'd5: alu_res = ~OP1;
            4'd6: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            4'd7: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            4'd8: begin
                alu_res = sra_w[WIDTH:1];
                alu_c   = sra_w[0];
            end
            4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
            4'd10: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
`ifdef ALU_PIPE_SAT_EN
        // Overflow direction follows OP1's sign for both ADD and SUB.
        if (alu_v) begin
            alu_res = OP1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        alu_flags = alu_err ? 4'b0000 : {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
    end

    always_comb begin
        mul_c   = |acc_nxt[2*WIDTH-1:WIDTH];
        mul_res = acc_nxt[WIDTH-1:0];
`ifdef ALU_PIPE_SAT_EN
        if (mul_c) begin
            mul_res = '1;
        end
`endif
        mul_flags = {mul_res[WIDTH-1], 1'b0, mul_c, (mul_res == '0)};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            RES       <= '0;
            FLAGS     <= 4'b0000;
            ERR       <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (OPCODE == 4'd10) begin
                            state     <= CALC;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            acc       <= '0;
                            mcand     <= {{WIDTH{1'b0}}, OP1};
                            mplier    <= OP2;
                            cnt       <= CW'(WIDTH);
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            RES       <= alu_res;
                            FLAGS     <= alu_flags;
                            ERR       <= alu_err;
                        end
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= HOLD;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        RES       <= mul_res;
                        FLAGS     <= mul_flags;
                        ERR       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8; expectations follow ALU_PIPE_SAT_EN.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] OP1;
    logic [W-1:0] OP2;
    logic [3:0]   OPCODE;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] RES;
    logic [3:0]   FLAGS;
    logic         ERR;
    logic         busy;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OP1       (OP1),
        .OP2       (OP2),
        .OPCODE    (OPCODE),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RES       (RES),
        .FLAGS     (FLAGS),
        .ERR       (ERR),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one single-cycle op, then checks the registered result one edge later.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic [3:0] exp_flags, input logic exp_err);
        OPCODE   = op;
        OP1      = a;
        OP2      = b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, 32'(RES), 32'(exp_res));
        check({tag, "_flags"}, 32'(FLAGS), 32'(exp_flags));
        check({tag, "_err"}, 32'(ERR), 32'(exp_err));
    endtask

    task automatic idle_cycle(input string tag);
        in_valid = 1'b0;
        tick();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        OP1       = '0;
        OP2       = '0;
        OPCODE    = 4'd0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_res", 32'(RES), 32'd0);
            check("rst_flags", 32'(FLAGS), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("post_rst_in_ready", 32'(in_ready), 32'd1);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
            check("post_rst_res", 32'(RES), 32'd0);
            check("post_rst_flags", 32'(FLAGS), 32'd0);
        end

        out_ready = 1'b1;
`ifdef ALU_PIPE_SAT_EN
        do_op("add_ovf", 4'd0, 8'h7F, 8'h01, 8'h7F, 4'b0100, 1'b0);
`else
        do_op("add_ovf", 4'd0, 8'h7F, 8'h01, 8'h80, 4'b1100, 1'b0);
`endif
        idle_cycle("add_ovf");

        // SUB then SRA back to back: the second accept retires the first result.
        do_op("sub_eq", 4'd1, 8'h04, 8'h04, 8'h00, 4'b0011, 1'b0);
        do_op("sra", 4'd8, 8'h90, 8'h03, 8'hF2, 4'b1000, 1'b0);
        idle_cycle("sra");

        do_op("shl", 4'd6, 8'h81, 8'h01, 8'h02, 4'b0010, 1'b0);
        do_op("shr0", 4'd7, 8'h81, 8'h00, 8'h81, 4'b1000, 1'b0);
        do_op("shr3", 4'd7, 8'h8C, 8'h03, 8'h11, 4'b0010, 1'b0);
        do_op("slt", 4'd9, 8'hFF, 8'h01, 8'h01, 4'b0000, 1'b0);
        do_op("not", 4'd5, 8'h0F, 8'h00, 8'hF0, 4'b1000, 1'b0);
        do_op("add_c", 4'd0, 8'hF0, 8'h20, 8'h10, 4'b0010, 1'b0);
        do_op("sub_bor", 4'd1, 8'h01, 8'h02, 8'hFF, 4'b1000, 1'b0);
        idle_cycle("misc");

        // MUL: ops offered during CALC must be ignored.
        OPCODE   = 4'd10;
        OP1      = 8'h10;
        OP2      = 8'h11;
        in_valid = 1'b1;
        check("mul_in_ready", 32'(in_ready), 32'd1);
        tick();
        OPCODE = 4'd0;
        OP1    = 8'h01;
        OP2    = 8'h01;
        for (int i = 0; i < 8; i++) begin
            check("mul_busy", 32'(busy), 32'd1);
            check("mul_in_ready_low", 32'(in_ready), 32'd0);
            check("mul_out_valid_low", 32'(out_valid), 32'd0);
            if (i == 7) in_valid = 1'b0;
            if (i < 7) tick();
        end
        tick();
        check("mul_out_valid", 32'(out_valid), 32'd1);
        check("mul_busy_done", 32'(busy), 32'd0);
`ifdef ALU_PIPE_SAT_EN
        check("mul_res", 32'(RES), 32'h0FF);
        check("mul_flags", 32'(FLAGS), 32'b1010);
`else
        check("mul_res", 32'(RES), 32'h010);
        check("mul_flags", 32'(FLAGS), 32'b0010);
`endif
        check("mul_err", 32'(ERR), 32'd0);
        idle_cycle("mul");

        // Backpressure: XOR result held for 5 cycles while an ADD is offered.
        out_ready = 1'b0;
        do_op("xor", 4'd4, 8'hA5, 8'h3C, 8'h99, 4'b1000, 1'b0);
        OPCODE   = 4'd0;
        OP1      = 8'h01;
        OP2      = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_res", 32'(RES), 32'h99);
            check("stall_flags", 32'(FLAGS), 32'b1000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_release", 32'(out_valid), 32'd0);
        check("stall_not_captured", 32'(RES), 32'h99);

        do_op("illegal", 4'hC, 8'h55, 8'h0F, 8'h00, 4'b0000, 1'b1);
        do_op("err_clear", 4'd0, 8'h01, 8'h01, 8'h02, 4'b0000, 1'b0);
        idle_cycle("err_clear");

        // Reset in the middle of a multiply must abort it.
        OPCODE   = 4'd10;
        OP1      = 8'h03;
        OP2      = 8'h05;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("abort_rst_busy", 32'(busy), 32'd0);
        check("abort_rst_out_valid", 32'(out_valid), 32'd0);
        check("abort_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        check("abort_busy_final", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
